// File: rtl/cursor_pkg.sv
// cursor_pkg: shared constants, scan state encoding and address helper for the cursor matrix driver.
package cursor_pkg;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int ADDR_W = 5;
  localparam int IDX_W = 4;
  localparam int ADDR_MIN = 1;
  localparam int ADDR_MAX = 16;
  typedef enum logic {ST_BLANK, ST_ON} scan_state_t;
  function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
    return a >= ADDR_W'(ADDR_MIN) && a <= ADDR_W'(ADDR_MAX);
  endfunction
endpackage

// File: rtl/cursor_matrix_drv_if.sv
// cursor_matrix_drv_if: cursor/cell inputs and LED matrix pin outputs of the matrix driver.
interface cursor_matrix_drv_if;
  import cursor_pkg::*;
  logic [ADDR_W-1:0] addr;
  logic [ROWS*COLS-1:0] cell_state;
  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col;
  logic frame_start;
  logic [1:0] cur_row;
  modport master(output addr, cell_state, input row_n, col, frame_start, cur_row);
  modport slave(input addr, cell_state, output row_n, col, frame_start, cur_row);
endinterface

// File: rtl/blink_gen.sv
// blink_gen: free-running square wave, level toggles every BLINK_DIV cycles, starts high.
module blink_gen #(
  parameter int BLINK_DIV = 6000000
) (
  input  logic clk_24m,
  input  logic rst_n,
  output logic blink_on
);
  localparam int W = $clog2(BLINK_DIV + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      blink_on <= 1'b1;
    end else if (cnt == W'(BLINK_DIV - 1)) begin
      cnt <= '0;
      blink_on <= ~blink_on;
    end else begin
      cnt <= cnt + W'(1);
    end
  end
endmodule

// File: rtl/cursor_matrix_drv.sv
// cursor_matrix_drv: row-scanned 4x4 LED matrix driver with a blinking, frame-latched cursor cell.
module cursor_matrix_drv import cursor_pkg::*; #(
  parameter int SCAN_DIV  = 24000,
  parameter int BLANK_CYC = 240,
  parameter int BLINK_DIV = 6000000
) (
  input logic clk_24m,
  input logic rst_n,
  cursor_matrix_drv_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  scan_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0] row, row_nx;
  logic [ROWS-1:0] row_n_q, row_n_nx;
  logic [COLS-1:0] col_q, col_nx, cur_mask;
  logic frame_q, frame_tick, cur_vld, blink_on;
  logic [IDX_W-1:0] cur_idx;

  blink_gen #(.BLINK_DIV(BLINK_DIV)) u_blink (.clk_24m(clk_24m), .rst_n(rst_n), .blink_on(blink_on));

  // first cycle of the row-0 slot: cursor is sampled here only, so a frame never tears
  assign frame_tick = cnt == '0 && row == 2'd0;
  assign cur_mask = (cur_vld && cur_idx[3:2] == row && blink_on) ? COLS'(1) << cur_idx[1:0] : '0;

  always_comb begin
    state_nx = state;
    cnt_nx = cnt + CW'(1);
    row_nx = row;
    row_n_nx = row_n_q;
    col_nx = col_q;
    if (state == ST_BLANK && cnt == CW'(BLANK_CYC - 1)) begin
      state_nx = ST_ON;
      row_n_nx = ~(ROWS'(1) << row);
      col_nx = bus.cell_state[{row, 2'b00} +: COLS] ^ cur_mask;
    end else if (state == ST_ON && cnt == CW'(SCAN_DIV - 1)) begin
      state_nx = ST_BLANK;
      cnt_nx = '0;
      row_nx = row + 2'd1;
      row_n_nx = '1;
      col_nx = '0;
    end
  end

  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BLANK;
      cnt <= '0;
      row <= '0;
      row_n_q <= '1;
      col_q <= '0;
      frame_q <= 1'b0;
      cur_vld <= 1'b0;
      cur_idx <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      row <= row_nx;
      row_n_q <= row_n_nx;
      col_q <= col_nx;
      frame_q <= frame_tick;
      if (frame_tick) begin
        cur_vld <= addr_valid(bus.addr);
        cur_idx <= IDX_W'(bus.addr - ADDR_W'(1));
      end
    end
  end

  assign bus.row_n = row_n_q;
  assign bus.col = col_q;
  assign bus.frame_start = frame_q;
  assign bus.cur_row = row;
endmodule
